// File: rtl/psd_pkg.sv
// Shared types and default sizes for the PSD readout path.
// Bin addresses, accumulator words and the readout FSM states.
package psd_pkg;

    localparam int N_BINS_DEF    = 1024;
    localparam int ACC_WIDTH_DEF = 48;
    localparam int OUT_WIDTH_DEF = 32;

    typedef logic [$clog2(N_BINS_DEF)-1:0] bin_addr_t;
    typedef logic [ACC_WIDTH_DEF-1:0]      acc_word_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } readout_state_t;

endpackage

// File: rtl/psd_readout_if.sv
// AXI-Stream style valid/ready bundle carrying normalised PSD bins.
interface Axis_If #(
    parameter int W = 32
);

    logic         valid;
    logic         ready;
    logic         last;
    logic [W-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/psd_readout_fifo.sv
// Small synchronous FIFO buffering normalised bins ahead of the stream.
module psd_readout_fifo #(
    parameter int W = 33,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/psd_readout.sv
// Streams PSD bins from the bin RAM, normalised and saturated,
// optionally clearing each bin once its read data has returned.
module psd_readout
    import psd_pkg::*;
#(
    parameter int N_BINS        = N_BINS_DEF,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH     = OUT_WIDTH_DEF,
    parameter int RAM_LATENCY   = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int CLEAR_ON_READ = 1,
    localparam int AW = $clog2(N_BINS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [5:0]           avg_shift,
    output logic                 busy,
    output logic                 ram_rd_en,
    output logic [AW-1:0]        ram_rd_addr,
    input  logic [ACC_WIDTH-1:0] ram_rd_data,
    output logic                 ram_wr_en,
    output logic [AW-1:0]        ram_wr_addr,
    Axis_If.master               data_out
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    readout_state_t       state;
    readout_state_t       state_nx;
    logic [AW-1:0]        addr;
    logic [5:0]           shift_q;
    logic [RAM_LATENCY-1:0] pipe_v;
    logic [AW-1:0]        pipe_a [RAM_LATENCY];
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        inflight;
    logic                 issue;
    logic                 room;
    logic                 tap;
    logic                 pop;
    logic                 empty;
    logic [ACC_WIDTH-1:0] y;
    logic [OUT_WIDTH-1:0] norm;
    logic [OUT_WIDTH:0]   fifo_din;
    logic [OUT_WIDTH:0]   fifo_dout;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++)
            inflight = inflight + CW'(pipe_v[i]);
    end

    // Reads in flight already own a FIFO slot, so no return is ever dropped.
    assign room  = (fifo_count + inflight) < CW'(FIFO_DEPTH);
    assign issue = reset_n &
                   ((state == IDLE && start) || (state == READ && room));
    assign pop   = data_out.valid & data_out.ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    if (issue && addr == AW'(N_BINS - 1)) state_nx = DRAIN;
            DRAIN:   if (pop && fifo_dout[OUT_WIDTH]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            addr    <= '0;
            shift_q <= '0;
            pipe_v  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) shift_q <= avg_shift;
            if (issue) addr <= addr + 1'b1;
            pipe_v[0] <= issue;
            for (int i = 1; i < RAM_LATENCY; i++)
                pipe_v[i] <= pipe_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_a[0] <= addr;
        for (int i = 1; i < RAM_LATENCY; i++)
            pipe_a[i] <= pipe_a[i-1];
    end

    assign tap = pipe_v[RAM_LATENCY-1];

    // Logical shift; shifts of ACC_WIDTH or more naturally yield zero.
    assign y    = ram_rd_data >> shift_q;
    assign norm = (|y[ACC_WIDTH-1:OUT_WIDTH]) ? '1 : y[OUT_WIDTH-1:0];

    assign fifo_din = {pipe_a[RAM_LATENCY-1] == AW'(N_BINS - 1), norm};

    psd_readout_fifo #(
        .W     (OUT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tap),
        .din     (fifo_din),
        .pop     (pop),
        .dout    (fifo_dout),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign busy        = (state != IDLE);
    assign ram_rd_en   = issue;
    assign ram_rd_addr = addr;
    assign ram_wr_en   = (CLEAR_ON_READ != 0) & tap;
    assign ram_wr_addr = pipe_a[RAM_LATENCY-1];

    assign data_out.valid = !empty;
    assign data_out.data  = fifo_dout[OUT_WIDTH-1:0];
    assign data_out.last  = !empty & fifo_dout[OUT_WIDTH];

endmodule

// File: tb/tb_psd_readout.sv
// Scoreboard bench for psd_readout with an 8-bin, 2-cycle-latency RAM model.
module tb_psd_readout;

    localparam int NB = 8;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  avg_shift = '0;
    logic        busy;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [47:0] rd_data;
    logic        wr_en;
    logic [2:0]  wr_addr;

    Axis_If #(.W(32)) axis ();

    psd_readout #(
        .N_BINS        (NB),
        .ACC_WIDTH     (48),
        .OUT_WIDTH     (32),
        .RAM_LATENCY   (LAT),
        .FIFO_DEPTH    (4),
        .CLEAR_ON_READ (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .avg_shift   (avg_shift),
        .busy        (busy),
        .ram_rd_en   (rd_en),
        .ram_rd_addr (rd_addr),
        .ram_rd_data (rd_data),
        .ram_wr_en   (wr_en),
        .ram_wr_addr (wr_addr),
        .data_out    (axis)
    );

    always #5 clk = ~clk;

    logic [47:0] ram  [NB];
    logic [47:0] init [NB];
    logic        load = 1'b0;
    logic [47:0] d1, d2;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < NB; i++) ram[i] <= init[i];
        end else if (wr_en) begin
            ram[wr_addr] <= '0;
        end
        if (rd_en) d1 <= ram[rd_addr];
        d2 <= d1;
    end
    assign rd_data = d2;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    beats = 0;
    int    cyc = 0;
    int    rd_cyc [NB];
    bit    rand_ready = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        axis.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axis.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit    stalled = 1'b0;
    beat_t held;
    beat_t e;

    always @(negedge clk) begin
        if (wr_en) check("clear_after_read", 64'(cyc - rd_cyc[wr_addr]), 64'(LAT));
        if (rd_en) rd_cyc[rd_addr] = cyc;
        if (stalled) begin
            check("stall_valid", 64'(axis.valid), 64'd1);
            check("stall_data", 64'(axis.data), 64'(held.data));
            check("stall_last", 64'(axis.last), 64'(held.last));
        end
        stalled   = reset_n && axis.valid && !axis.ready;
        held.data = axis.data;
        held.last = axis.last;
        if (axis.valid && axis.ready) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("beat_data", 64'(axis.data), 64'(e.data));
                check("beat_last", 64'(axis.last), 64'(e.last));
                beats++;
            end
        end
    end

    task automatic do_load();
        @(posedge clk);
        #1 load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic fill_linear(input int offs);
        for (int i = 0; i < NB; i++) init[i] = 48'(i * 16 + offs);
    endtask

    task automatic expect_frame(input int sh);
        logic [63:0] y;
        beat_t b;
        for (int i = 0; i < NB; i++) begin
            y = {16'd0, init[i]} >> sh;
            b.data = (y > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : y[31:0];
            b.last = (i == NB - 1);
            sb.push_back(b);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_timeout", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("frame_all_beats", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic pulse_start(input int sh);
        start = 1'b1;
        avg_shift = 6'(sh);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_frame(input int sh, input bit mid);
        expect_frame(sh);
        pulse_start(sh);
        check("busy_after_start", 64'(busy), 64'd1);
        if (mid) begin
            repeat (2) @(posedge clk);
            #1;
            pulse_start(0);
        end
        wait_idle();
    endtask

    task automatic check_cleared();
        for (int i = 0; i < NB; i++)
            check("ram_cleared", 64'(ram[i]), 64'd0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(axis.valid), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_last", 64'(axis.last), 64'd0);
        reset_n = 1'b1;

        fill_linear(0);
        do_load();
        run_frame(4, 1'b0);
        check_cleared();

        do_load();
        rand_ready = 1'b1;
        run_frame(4, 1'b0);
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        check_cleared();

        fill_linear(0);
        init[3] = 48'h010000000000;
        do_load();
        run_frame(0, 1'b0);

        do_load();
        run_frame(63, 1'b0);

        fill_linear(0);
        do_load();
        run_frame(4, 1'b1);

        fill_linear(5);
        do_load();
        expect_frame(4);
        n = beats;
        pulse_start(4);
        while (beats < n + 4 && beats < n + 100) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        check("mid_rst_valid", 64'(axis.valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        reset_n = 1'b1;
        fill_linear(5);
        do_load();
        run_frame(4, 1'b0);
        check_cleared();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
